// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_ITERS = DIV_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_sub17.sv
// Combinational subtractor: diff = a - b, borrow set when b > a.
module div_sub17 #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    always_comb begin
        {borrow, diff} = {1'b0, a} - {1'b0, b};
    end

endmodule

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle,
// signed (truncating) or unsigned operands.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic             ovf
);

    localparam int ITERS = (WIDTH == DIV_WIDTH) ? DIV_ITERS : WIDTH;
    localparam int CW    = $clog2(ITERS + 1);

    div_state_t state, state_nx;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic             negq, negr, ovf_c, dbz_c;
    logic [WIDTH:0]   shifted, diff;
    logic             borrow;
    logic             diff_msb_unused;

    function automatic logic [WIDTH-1:0] mag(input logic s,
                                             input logic [WIDTH-1:0] x);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    assign shifted         = {rem, acc[WIDTH-1]};
    assign diff_msb_unused = diff[WIDTH];

    div_sub17 #(.W(WIDTH + 1)) u_sub (
        .a      (shifted),
        .b      ({1'b0, dsr}),
        .diff   (diff),
        .borrow (borrow)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Divide-by-zero skips RUN but still passes through FIX to load results.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = (divisor == '0) ? FIX : RUN;
            RUN:  if (cnt == CW'(1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            dsr       <= '0;
            dvd       <= '0;
            rem       <= '0;
            negq      <= 1'b0;
            negr      <= 1'b0;
            ovf_c     <= 1'b0;
            dbz_c     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dvd   <= dividend;
                    acc   <= mag(sgn, dividend);
                    dsr   <= mag(sgn, divisor);
                    rem   <= '0;
                    negq  <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    negr  <= sgn & dividend[WIDTH-1];
                    ovf_c <= sgn && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                                 && (divisor == '1);
                    dbz_c <= (divisor == '0);
                    cnt   <= (divisor == '0) ? '0 : CW'(ITERS);
                    dbz   <= 1'b0;
                    ovf   <= 1'b0;
                end
                RUN: begin
                    rem <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    acc <= {acc[WIDTH-2:0], ~borrow};
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    if (dbz_c) begin
                        quotient  <= '1;
                        remainder <= dvd;
                        dbz       <= 1'b1;
                    end else begin
                        quotient  <= negq ? -acc : acc;
                        remainder <= negr ? -rem : rem;
                        ovf       <= ovf_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
